// File: rtl/sparc_exu_ecc_scrub_ctl_if.sv
// Scrub-controller signal bundle: ECC report input, RF read/write port handshakes, status outputs.
// Latency: none (wires only).
// Backpressure: rf_rd_gnt / rf_wr_gnt stall the controller; ce reports are never backpressured.
//
// Ports (slave = controller side):
//   ce_vld_m/ce_reg_m  corrected-error report {gl[2:0], rd[4:0]}
//   scrub_en, ovf_clr  drain enable, sticky-overflow clear
//   rf_rd_req/gnt, rf_chk_ce/ue, rf_wr_req/gnt, rf_addr  register-file access
//   scrub_done, scrub_ue, q_cnt, q_ovf, busy, stat_fix, stat_ue  status
interface sparc_exu_ecc_scrub_ctl_if;
  logic        ce_vld_m;
  logic [7:0]  ce_reg_m;
  logic        scrub_en;
  logic        ovf_clr;
  logic        rf_rd_req;
  logic        rf_rd_gnt;
  logic        rf_chk_ce;
  logic        rf_chk_ue;
  logic        rf_wr_req;
  logic        rf_wr_gnt;
  logic [7:0]  rf_addr;
  logic        scrub_done;
  logic        scrub_ue;
  logic [2:0]  q_cnt;
  logic        q_ovf;
  logic        busy;
  logic [15:0] stat_fix;
  logic [15:0] stat_ue;

  modport slave (
    input  ce_vld_m, ce_reg_m, scrub_en, ovf_clr, rf_rd_gnt, rf_chk_ce, rf_chk_ue, rf_wr_gnt,
    output rf_rd_req, rf_wr_req, rf_addr, scrub_done, scrub_ue, q_cnt, q_ovf, busy,
           stat_fix, stat_ue
  );

  modport master (
    output ce_vld_m, ce_reg_m, scrub_en, ovf_clr, rf_rd_gnt, rf_chk_ce, rf_chk_ue, rf_wr_gnt,
    input  rf_rd_req, rf_wr_req, rf_addr, scrub_done, scrub_ue, q_cnt, q_ovf, busy,
           stat_fix, stat_ue
  );
endinterface

// File: rtl/sparc_exu_ecc_scrub_ctl.sv
// Queues corrected-error register reports and scrubs each one: RF read, ECC re-check, corrected write.
// Latency: 4 cycles push to scrub_done with immediate grants (RD, CHK, WR, done pulse).
// Backpressure: RD/WR hold their request until granted; reports arriving while full are dropped and flagged.
//
// Ports: clk, arst_l (async, active-low) plain; everything else via sparc_exu_ecc_scrub_ctl_if.slave.
// Optional: define EXU_SCRUB_STATS_EN to enable saturating stat_fix / stat_ue counters
// (otherwise both outputs are tied to zero).
module sparc_exu_ecc_scrub_ctl #(
  parameter int QDEPTH = 4
) (
  input  logic                            clk,
  input  logic                            arst_l,
  sparc_exu_ecc_scrub_ctl_if.slave        sif
);
  localparam int             PW    = $clog2(QDEPTH);
  localparam logic [PW:0]    QFULL = (PW+1)'(QDEPTH);

  typedef enum logic [1:0] {IDLE, RD, CHK, WR} state_t;

  state_t            state_q, state_d;
  logic [7:0]        q_mem_q [QDEPTH];
  logic [QDEPTH-1:0] q_vld_q, q_vld_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       cnt_q;
  logic [3:0]        cnt_x;
  logic              q_ovf_q, done_q, ue_q;
  logic              done_d, ue_d, fix_d, pop;
  logic              dup_hit, full, push_ok, push_ovf;

  // A report matching any queued register is already covered; drop it quietly.
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < QDEPTH; i++)
      if (q_vld_q[i] && (q_mem_q[i] == sif.ce_reg_m)) dup_hit = 1'b1;
  end

  assign full     = (cnt_q == QFULL);
  // A pop in the same cycle frees the head slot, so a push into a full queue still fits.
  assign push_ok  = sif.ce_vld_m && !dup_hit && (!full || pop);
  assign push_ovf = sif.ce_vld_m && !dup_hit && full && !pop;
  assign pop      = done_d || ue_d;

  always_comb begin
    q_vld_d = q_vld_q;
    if (pop)     q_vld_d[rd_ptr_q] = 1'b0;
    if (push_ok) q_vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      q_vld_q  <= '0;
      q_ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      q_vld_q <= q_vld_d;
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      // A new overflow wins over a same-cycle clear.
      if (push_ovf)         q_ovf_q <= 1'b1;
      else if (sif.ovf_clr) q_ovf_q <= 1'b0;
    end
  end

  // Entry payload needs no reset: it is only observed through q_vld_q or while busy.
  always_ff @(posedge clk) begin
    if (push_ok) q_mem_q[wr_ptr_q] <= sif.ce_reg_m;
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      ue_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      ue_q    <= ue_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    ue_d    = 1'b0;
    fix_d   = 1'b0;
    case (state_q)
      // An accepted push into an empty queue starts service in the same cycle.
      IDLE: if (sif.scrub_en && ((cnt_q != '0) || push_ok)) state_d = RD;
      RD:   if (sif.rf_rd_gnt) state_d = CHK;
      CHK: begin
        if (sif.rf_chk_ue) begin
          ue_d    = 1'b1;
          state_d = IDLE;
        end else if (sif.rf_chk_ce) begin
          state_d = WR;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WR: if (sif.rf_wr_gnt) begin
        done_d  = 1'b1;
        fix_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // q_cnt is 3 bits; a full 8-deep queue reads back as 7.
  assign cnt_x          = 4'(cnt_q);
  assign sif.q_cnt      = cnt_x[3] ? 3'd7 : cnt_x[2:0];
  assign sif.q_ovf      = q_ovf_q;
  assign sif.busy       = (state_q != IDLE);
  assign sif.rf_rd_req  = (state_q == RD);
  assign sif.rf_wr_req  = (state_q == WR);
  assign sif.rf_addr    = (state_q != IDLE) ? q_mem_q[rd_ptr_q] : 8'h00;
  assign sif.scrub_done = done_q;
  assign sif.scrub_ue   = ue_q;

`ifdef EXU_SCRUB_STATS_EN
  logic [15:0] stat_fix_q, stat_ue_q;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      stat_fix_q <= '0;
      stat_ue_q  <= '0;
    end else begin
      if (fix_d && (stat_fix_q != 16'hFFFF)) stat_fix_q <= stat_fix_q + 1'b1;
      if (ue_d  && (stat_ue_q  != 16'hFFFF)) stat_ue_q  <= stat_ue_q + 1'b1;
    end
  end

  assign sif.stat_fix = stat_fix_q;
  assign sif.stat_ue  = stat_ue_q;
`else
  logic unused_fix;
  assign unused_fix   = fix_d;
  assign sif.stat_fix = 16'h0000;
  assign sif.stat_ue  = 16'h0000;
`endif
endmodule

// File: tb/tb_sparc_exu_ecc_scrub_ctl.sv
// Directed bench for the ECC scrub controller: timing, dedup, overflow, UE path, write stall, reset.
// Latency: n/a.
// Backpressure: grants driven directly by the bench.
module tb_sparc_exu_ecc_scrub_ctl;
  logic clk = 1'b0;
  logic arst_l = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  sparc_exu_ecc_scrub_ctl_if sif ();

  sparc_exu_ecc_scrub_ctl #(.QDEPTH(4)) dut (
    .clk    (clk),
    .arst_l (arst_l),
    .sif    (sif)
  );

  always #5 clk = ~clk;

`ifdef EXU_SCRUB_STATS_EN
  localparam logic [15:0] EXP_FIX = 16'd2;
  localparam logic [15:0] EXP_UE  = 16'd1;
`else
  localparam logic [15:0] EXP_FIX = 16'd0;
  localparam logic [15:0] EXP_UE  = 16'd0;
`endif

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] r);
    sif.ce_vld_m = 1'b1;
    sif.ce_reg_m = r;
    step();
    sif.ce_vld_m = 1'b0;
  endtask

  // Service one queued entry with immediate grants; ce/ue is the check result in CHK.
  task automatic serve(input logic [7:0] a, input logic ce, input logic ue, input logic [2:0] cnt);
    int n = 0;
    while (!sif.rf_rd_req && n < 10) begin
      step();
      n++;
    end
    chk("rd_req_wait", 16'(sif.rf_rd_req), 16'd1);
    chk("rd_addr", 16'(sif.rf_addr), 16'(a));
    step();
    sif.rf_chk_ce = ce;
    sif.rf_chk_ue = ue;
    step();
    sif.rf_chk_ce = 1'b0;
    sif.rf_chk_ue = 1'b0;
    if (ue) begin
      chk("ue_pulse", 16'(sif.scrub_ue), 16'd1);
      chk("ue_no_wr", 16'(sif.rf_wr_req), 16'd0);
      chk("ue_no_done", 16'(sif.scrub_done), 16'd0);
    end else if (ce) begin
      chk("wr_req", 16'(sif.rf_wr_req), 16'd1);
      chk("wr_addr", 16'(sif.rf_addr), 16'(a));
      step();
      chk("fix_done", 16'(sif.scrub_done), 16'd1);
    end else begin
      chk("clean_done", 16'(sif.scrub_done), 16'd1);
      chk("clean_no_wr", 16'(sif.rf_wr_req), 16'd0);
    end
    chk("cnt_after_pop", 16'(sif.q_cnt), 16'(cnt));
  endtask

  initial begin
    sif.ce_vld_m  = 1'b0;
    sif.ce_reg_m  = 8'h00;
    sif.scrub_en  = 1'b0;
    sif.ovf_clr   = 1'b0;
    sif.rf_rd_gnt = 1'b1;
    sif.rf_wr_gnt = 1'b1;
    sif.rf_chk_ce = 1'b0;
    sif.rf_chk_ue = 1'b0;

    // Reset state, observed before any clock edge
    #3;
    chk("rst_busy", 16'(sif.busy), 16'd0);
    chk("rst_qcnt", 16'(sif.q_cnt), 16'd0);
    chk("rst_qovf", 16'(sif.q_ovf), 16'd0);
    chk("rst_rdreq", 16'(sif.rf_rd_req), 16'd0);
    chk("rst_addr", 16'(sif.rf_addr), 16'd0);
    step();
    step();
    arst_l = 1'b1;
    step();

    // Single correction, immediate grants: RD c1, CHK c2, WR c3, done c4
    sif.scrub_en  = 1'b1;
    sif.rf_chk_ce = 1'b1;
    push(8'h2A);
    chk("t1_c1_rdreq", 16'(sif.rf_rd_req), 16'd1);
    chk("t1_c1_addr", 16'(sif.rf_addr), 16'h2A);
    chk("t1_c1_qcnt", 16'(sif.q_cnt), 16'd1);
    step();
    chk("t1_c2_rdreq", 16'(sif.rf_rd_req), 16'd0);
    chk("t1_c2_busy", 16'(sif.busy), 16'd1);
    step();
    chk("t1_c3_wrreq", 16'(sif.rf_wr_req), 16'd1);
    step();
    chk("t1_c4_done", 16'(sif.scrub_done), 16'd1);
    chk("t1_c4_qcnt", 16'(sif.q_cnt), 16'd0);
    chk("t1_c4_busy", 16'(sif.busy), 16'd0);
    chk("t1_c4_addr", 16'(sif.rf_addr), 16'd0);
    step();
    chk("t1_c5_done_pulse", 16'(sif.scrub_done), 16'd0);
    sif.rf_chk_ce = 1'b0;

    // Duplicate suppression with drain disabled
    sif.scrub_en = 1'b0;
    push(8'h05);
    push(8'h05);
    push(8'h11);
    chk("dup_qcnt", 16'(sif.q_cnt), 16'd2);
    chk("dup_qovf", 16'(sif.q_ovf), 16'd0);

    // Fill to 4, overflow, clear, dup while full, overflow racing clear
    push(8'h20);
    push(8'h21);
    chk("fill_qcnt", 16'(sif.q_cnt), 16'd4);
    chk("fill_qovf", 16'(sif.q_ovf), 16'd0);
    push(8'h22);
    chk("ovf_set", 16'(sif.q_ovf), 16'd1);
    chk("ovf_qcnt", 16'(sif.q_cnt), 16'd4);
    sif.ovf_clr = 1'b1;
    step();
    sif.ovf_clr = 1'b0;
    chk("ovf_clr", 16'(sif.q_ovf), 16'd0);
    push(8'h05);
    chk("dup_full_no_ovf", 16'(sif.q_ovf), 16'd0);
    sif.ovf_clr = 1'b1;
    push(8'h23);
    chk("ovf_beats_clr", 16'(sif.q_ovf), 16'd1);
    step();
    sif.ovf_clr = 1'b0;
    chk("ovf_clr2", 16'(sif.q_ovf), 16'd0);
    chk("held_busy", 16'(sif.busy), 16'd0);

    // Drain in FIFO order: UE, clean, correct+write, clean
    sif.scrub_en = 1'b1;
    serve(8'h05, 1'b0, 1'b1, 3'd3);
    serve(8'h11, 1'b0, 1'b0, 3'd2);
    serve(8'h20, 1'b1, 1'b0, 3'd1);
    serve(8'h21, 1'b0, 1'b0, 3'd0);
    chk("stat_fix", sif.stat_fix, EXP_FIX);
    chk("stat_ue", sif.stat_ue, EXP_UE);

    // Write-port stall for 6 cycles, push during stall, push+pop on grant
    step();
    sif.rf_wr_gnt = 1'b0;
    sif.rf_chk_ce = 1'b1;
    push(8'h33);
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      chk("stall_wrreq", 16'(sif.rf_wr_req), 16'd1);
      chk("stall_addr", 16'(sif.rf_addr), 16'h33);
      if (i == 1) begin
        sif.ce_vld_m = 1'b1;
        sif.ce_reg_m = 8'h44;
      end
      step();
      sif.ce_vld_m = 1'b0;
    end
    chk("stall_qcnt", 16'(sif.q_cnt), 16'd2);
    sif.rf_wr_gnt = 1'b1;
    push(8'h55);
    sif.rf_wr_gnt = 1'b0;
    chk("pushpop_done", 16'(sif.scrub_done), 16'd1);
    chk("pushpop_qcnt", 16'(sif.q_cnt), 16'd2);

    // Reset while in WR for the next entry
    step();
    chk("next_addr", 16'(sif.rf_addr), 16'h44);
    step();
    step();
    chk("pre_rst_wrreq", 16'(sif.rf_wr_req), 16'd1);
    #2;
    arst_l = 1'b0;
    #1;
    chk("mid_rst_wrreq", 16'(sif.rf_wr_req), 16'd0);
    chk("mid_rst_busy", 16'(sif.busy), 16'd0);
    chk("mid_rst_qcnt", 16'(sif.q_cnt), 16'd0);
    chk("mid_rst_addr", 16'(sif.rf_addr), 16'd0);
    chk("mid_rst_stat", sif.stat_fix, 16'd0);
    step();
    arst_l = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_wrreq", 16'(sif.rf_wr_req), 16'd0);
    end
    chk("post_rst_qcnt", 16'(sif.q_cnt), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
